card_display_ctrl: RTL and testbench

//  N-channel registered card display driver. Replaces the per-digit combinational card decoder in the baccarat datapath.
//  - Latches one 4-bit card code per channel and drives one 7-seg digit per channel.
//  - Adds a deal-flash animation on each new card, optional steady blink, and selectable output polarity and bit order.
//  - Sits between the player/dealer card registers and the HEX pins.

---
 rtl/card_disp_pkg.sv | 61 ++++++
 rtl/card_display_ctrl_if.sv | 12 +
 rtl/card_disp_chan.sv | 68 ++++++
 rtl/card_display_ctrl.sv | 60 ++++++
 tb/tb_card_display_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/card_disp_pkg.sv
// Shared card codes, 7-segment glyph constants and the card-to-glyph decoder
// used by every display channel.
package card_disp_pkg;

  localparam logic [3:0] CARD_BLANK = 4'd0;
  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] CARD_2     = 4'd2;
  localparam logic [3:0] CARD_3     = 4'd3;
  localparam logic [3:0] CARD_4     = 4'd4;
  localparam logic [3:0] CARD_5     = 4'd5;
  localparam logic [3:0] CARD_6     = 4'd6;
  localparam logic [3:0] CARD_7     = 4'd7;
  localparam logic [3:0] CARD_8     = 4'd8;
  localparam logic [3:0] CARD_9     = 4'd9;
  localparam logic [3:0] CARD_10    = 4'd10;
  localparam logic [3:0] CARD_JACK  = 4'd11;
  localparam logic [3:0] CARD_QUEEN = 4'd12;
  localparam logic [3:0] CARD_KING  = 4'd13;

  // Canonical segment order: bit6=a .. bit0=g
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ACE   = 7'b1110111;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_10    = 7'b1111110;
  localparam logic [6:0] SEG_JACK  = 7'b0111100;
  localparam logic [6:0] SEG_QUEEN = 7'b1110011;
  localparam logic [6:0] SEG_KING  = 7'b0110111;

  function automatic logic [6:0] card_glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      CARD_ACE:   seg = SEG_ACE;
      CARD_2:     seg = SEG_2;
      CARD_3:     seg = SEG_3;
      CARD_4:     seg = SEG_4;
      CARD_5:     seg = SEG_5;
      CARD_6:     seg = SEG_6;
      CARD_7:     seg = SEG_7;
      CARD_8:     seg = SEG_8;
      CARD_9:     seg = SEG_9;
      CARD_10:    seg = SEG_10;
      CARD_JACK:  seg = SEG_JACK;
      CARD_QUEEN: seg = SEG_QUEEN;
      CARD_KING:  seg = SEG_KING;
      default:    seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic is_card(input logic [3:0] code);
    return (code >= CARD_ACE) && (code <= CARD_KING);
  endfunction

endpackage

// File: rtl/card_display_ctrl_if.sv
// Card-register side and HEX-pin side signals of the card display driver.
interface card_display_ctrl_if #(parameter int NCH = 3);
  logic [NCH-1:0]   load;
  logic [4*NCH-1:0] card_in;
  logic             clear;
  logic [NCH-1:0]   blink_en;
  logic [NCH-1:0]   valid;
  logic [7*NCH-1:0] hex_out;

  modport master (output load, card_in, clear, blink_en, input valid, hex_out);
  modport slave  (input load, card_in, clear, blink_en, output valid, hex_out);
endinterface

// File: rtl/card_disp_chan.sv
// One display digit: latched card code, deal-flash counter, blink gating and
// the registered segment output with polarity/bit-order mapping.
module card_disp_chan
  import card_disp_pkg::*;
#(
  parameter int FLASH_TICKS = 4,
  parameter int ACTIVE_LOW  = 0,
  parameter int BIT0_IS_A   = 0
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] card,
  input  logic       blink_en,
  input  logic       tick,
  input  logic       phase,
  output logic       valid,
  output logic [6:0] hex
);

  localparam int FW = (FLASH_TICKS < 1) ? 1 : $clog2(FLASH_TICKS + 1);
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [3:0]    card_q;
  logic [FW-1:0] flash_cnt;
  logic [6:0]    gated;
  logic [6:0]    ordered;
  logic [6:0]    hex_d;
  logic          visible;

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      card_q    <= CARD_BLANK;
      flash_cnt <= '0;
    end else if (clear) begin
      card_q    <= CARD_BLANK;
      flash_cnt <= '0;
    end else if (load) begin
      card_q    <= card;
      flash_cnt <= is_card(card) ? FW'(FLASH_TICKS) : '0;
    end else if (tick && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - FW'(1);
    end
  end

  // A flashing or blinking digit is only lit during the high blink phase
  always_comb begin
    visible = ((flash_cnt == '0) && !blink_en) || phase;
    gated   = visible ? card_glyph(card_q) : SEG_BLANK;
    ordered = gated;
    if (BIT0_IS_A != 0) begin
      for (int i = 0; i < 7; i++) ordered[i] = gated[6-i];
    end
    hex_d = (ACTIVE_LOW != 0) ? ~ordered : ordered;
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      hex   <= SEG_OFF;
      valid <= 1'b0;
    end else begin
      hex   <= hex_d;
      valid <= is_card(card_q);
    end
  end

endmodule

// File: rtl/card_display_ctrl.sv
// N-channel registered card display driver: shared blink timebase plus one
// card_disp_chan per digit.
module card_display_ctrl
  import card_disp_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int BLINK_DIV   = 4,
  parameter int FLASH_TICKS = 4,
  parameter int ACTIVE_LOW  = 0,
  parameter int BIT0_IS_A   = 0
) (
  input  logic           slow_clock,
  input  logic           resetb,
  card_display_ctrl_if.slave bus
);

  localparam int DW = $clog2(BLINK_DIV);

  logic [DW-1:0]  div_cnt;
  logic           phase;
  logic           tick;
  logic [NCH-1:0] load_eff;

  assign tick = (div_cnt == DW'(BLINK_DIV - 1));

  // Timebase free-runs through clear so blink rhythm is not disturbed by a new hand
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign load_eff = bus.load & ~{NCH{bus.clear}};

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    card_disp_chan #(
      .FLASH_TICKS (FLASH_TICKS),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .BIT0_IS_A   (BIT0_IS_A)
    ) u_chan (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .clear      (bus.clear),
      .load       (load_eff[i]),
      .card       (bus.card_in[4*i +: 4]),
      .blink_en   (bus.blink_en[i]),
      .tick       (tick),
      .phase      (phase),
      .valid      (bus.valid[i]),
      .hex        (bus.hex_out[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_card_display_ctrl.sv
// Randomized bench for card_display_ctrl against a tick/cycle-count reference
// model, plus a polarity/bit-order instance exercised over every card code.
module tb_card_display_ctrl;

  localparam int NCH = 3;
  localparam int BD  = 4;
  localparam int FT  = 4;

  logic clk;
  logic resetb;
  logic resetb2;

  card_display_ctrl_if #(.NCH(NCH)) bus  ();
  card_display_ctrl_if #(.NCH(NCH)) bus2 ();

  card_display_ctrl #(.NCH(NCH), .BLINK_DIV(BD), .FLASH_TICKS(FT),
                      .ACTIVE_LOW(0), .BIT0_IS_A(0))
    u_dut (.slow_clock(clk), .resetb(resetb), .bus(bus));

  card_display_ctrl #(.NCH(NCH), .BLINK_DIV(BD), .FLASH_TICKS(0),
                      .ACTIVE_LOW(1), .BIT0_IS_A(1))
    u_dut2 (.slow_clock(clk), .resetb(resetb2), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16];
  initial begin
    glyph_tab[0]  = 7'b0000000; glyph_tab[1]  = 7'b1110111;
    glyph_tab[2]  = 7'b1101101; glyph_tab[3]  = 7'b1111001;
    glyph_tab[4]  = 7'b0110011; glyph_tab[5]  = 7'b1011011;
    glyph_tab[6]  = 7'b1011111; glyph_tab[7]  = 7'b1110000;
    glyph_tab[8]  = 7'b1111111; glyph_tab[9]  = 7'b1111011;
    glyph_tab[10] = 7'b1111110; glyph_tab[11] = 7'b0111100;
    glyph_tab[12] = 7'b1110011; glyph_tab[13] = 7'b0110111;
    glyph_tab[14] = 7'b0000000; glyph_tab[15] = 7'b0000000;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: blink phase from edges since reset, flash as an end tick index
  int m_card [NCH];
  int m_flash_end [NCH];
  int m_ticks;
  int m_cyc;
  logic [7*NCH-1:0] exp_hex;
  logic [NCH-1:0]   exp_valid;

  function automatic logic code_valid(input int c);
    return (c >= 1) && (c <= 13);
  endfunction

  task automatic step();
    int ph;
    logic vis;
    @(posedge clk);
    ph = (m_cyc / BD) % 2;
    for (int ch = 0; ch < NCH; ch++) begin
      vis = (!(m_ticks < m_flash_end[ch]) && !bus.blink_en[ch]) || (ph == 1);
      exp_hex[7*ch +: 7] = vis ? glyph_tab[m_card[ch]] : 7'b0;
      exp_valid[ch]      = code_valid(m_card[ch]);
    end
    if (!resetb) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_card[ch] = 0;
        m_flash_end[ch] = 0;
      end
      m_ticks = 0;
      m_cyc = 0;
      exp_hex = '0;
      exp_valid = '0;
    end else begin
      if ((m_cyc % BD) == BD - 1) m_ticks++;
      m_cyc++;
      for (int ch = 0; ch < NCH; ch++) begin
        if (bus.clear) begin
          m_card[ch] = 0;
          m_flash_end[ch] = m_ticks;
        end else if (bus.load[ch]) begin
          m_card[ch] = int'(bus.card_in[4*ch +: 4]);
          m_flash_end[ch] = code_valid(m_card[ch]) ? m_ticks + FT : m_ticks;
        end
      end
    end
    #1;
    chk("hex_out", 32'(bus.hex_out), 32'(exp_hex));
    chk("valid", 32'(bus.valid), 32'(exp_valid));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic logic [6:0] rev_inv(input logic [6:0] g);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = g[6-i];
    return ~r;
  endfunction

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      m_card[ch] = 0;
      m_flash_end[ch] = 0;
    end
    m_ticks = 0;
    m_cyc = 0;
    resetb = 1'b0;
    resetb2 = 1'b0;
    bus.load = '0; bus.card_in = '0; bus.clear = 1'b0; bus.blink_en = '0;
    bus2.load = '0; bus2.card_in = '0; bus2.clear = 1'b0; bus2.blink_en = '0;

    // Reset and first edge after reset
    idle(2);
    resetb = 1'b1;
    step();
    chk("rst_hex", 32'(bus.hex_out), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);

    // Ace on ch0: flash then steady
    bus.load = 3'b001; bus.card_in = 12'h001;
    step();
    bus.load = '0;
    step();
    chk("ace_valid", 32'(bus.valid[0]), 32'h1);
    idle(40);
    chk("ace_steady", 32'(bus.hex_out[6:0]), 32'(7'b1110111));

    // Load king with clear in the same cycle: clear wins
    bus.load = 3'b010; bus.card_in = 12'h0D0; bus.clear = 1'b1;
    step();
    bus.load = '0; bus.clear = 1'b0;
    idle(6);
    chk("clr_wins_valid", 32'(bus.valid[1]), 32'h0);
    chk("clr_wins_hex", 32'(bus.hex_out[13:7]), 32'h0);

    // Code 14 then queen on ch2
    bus.load = 3'b100; bus.card_in = 12'hE00;
    step();
    bus.load = '0;
    step();
    chk("c14_hex", 32'(bus.hex_out[20:14]), 32'h0);
    chk("c14_valid", 32'(bus.valid[2]), 32'h0);
    bus.load = 3'b100; bus.card_in = 12'hC00;
    step();
    bus.load = '0;
    idle(40);
    chk("queen_steady", 32'(bus.hex_out[20:14]), 32'(7'b1110011));

    // Steady blink on ch0, then reset mid-blink
    bus.load = 3'b001; bus.card_in = 12'h001;
    step();
    bus.load = '0;
    idle(40);
    bus.blink_en = 3'b001;
    idle(21);
    resetb = 1'b0;
    step();
    chk("blink_rst_hex", 32'(bus.hex_out), 32'h0);
    resetb = 1'b1;
    bus.blink_en = '0;
    step();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bus.load    = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
      bus.card_in = 12'($urandom);
      bus.clear   = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 25) == 0) bus.blink_en = NCH'($urandom);
      resetb      = ($urandom_range(0, 400) != 0);
      step();
    end
    resetb = 1'b1;
    bus.load = '0; bus.clear = 1'b0; bus.blink_en = '0;

    // Inverted, bit-reversed, no-flash instance
    step();
    chk("al_rst_hex", 32'(bus2.hex_out), 32'h1FFFFF);
    chk("al_rst_valid", 32'(bus2.valid), 32'h0);
    resetb2 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus2.load = 3'b111;
      bus2.card_in = {3{4'(c)}};
      step();
      bus2.load = '0;
      step();
      for (int ch = 0; ch < NCH; ch++)
        chk($sformatf("al_glyph_c%0d_ch%0d", c, ch), 32'(bus2.hex_out[7*ch +: 7]),
            32'(rev_inv(glyph_tab[c])));
      chk($sformatf("al_valid_c%0d", c), 32'(bus2.valid), code_valid(c) ? 32'h7 : 32'h0);
    end
    bus2.load = 3'b001; bus2.card_in = 12'h00D;
    step();
    bus2.load = '0;
    step();
    chk("al_king", 32'(bus2.hex_out[6:0]), 32'(7'b0001001));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
